// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_minuend,
   input  logic [WIDTH-1:0] i_subtrahend,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result,
   output logic             o_borrow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, work_q, result_q;
   logic [WIDTH-1:0] work_d;
   logic             br_q, borrow_q;
   logic             diff_bit, br_d, last_bit;
   logic [CW-1:0]    cnt_q;

   always_comb begin
      diff_bit = a_q[0] ^ b_q[0] ^ br_q;
      br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      work_d   = {diff_bit, work_q[WIDTH-1:1]};
      last_bit = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         work_q   <= '0;
         result_q <= '0;
         br_q     <= 1'b0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               // DONE accepts a start too, so held i_start runs back-to-back
               if (i_start) begin
                  a_q     <= i_minuend;
                  b_q     <= i_subtrahend;
                  work_q  <= '0;
                  br_q    <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_RUN;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               a_q    <= a_q >> 1;
               b_q    <= b_q >> 1;
               br_q   <= br_d;
               work_q <= work_d;
               cnt_q  <= cnt_q + CW'(1);
               if (last_bit) begin
                  result_q <= work_d;
                  borrow_q <= br_d;
                  state_q  <= S_DONE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_busy   = (state_q == S_RUN);
   assign o_done   = (state_q == S_DONE);
   assign o_result = result_q;
   assign o_borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed-vector bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] minuend, subtrahend;
   logic       busy, done, borrow;
   logic [7:0] result;

   int total = 0;
   int bad   = 0;

   serial_subtractor #(.WIDTH(8)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_minuend    (minuend),
      .i_subtrahend (subtrahend),
      .o_busy       (busy),
      .o_done       (done),
      .o_result     (result),
      .o_borrow     (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation with single start pulse; operands scrambled after acceptance.
   task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] er, input logic eb);
      logic [7:0] prev_r;
      logic       prev_b;
      prev_r = result;
      prev_b = borrow;
      @(negedge clk);
      start = 1'b1;
      minuend = a;
      subtrahend = b;
      tick();
      start = 1'b0;
      minuend = 8'($urandom);
      subtrahend = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_nodone"}, 32'(done), 32'd0);
         check({tag, "_hold_r"}, 32'(result), 32'(prev_r));
         check({tag, "_hold_b"}, 32'(borrow), 32'(prev_b));
         tick();
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_lo"}, 32'(busy), 32'd0);
      check({tag, "_result"}, 32'(result), 32'(er));
      check({tag, "_borrow"}, 32'(borrow), 32'(eb));
      tick();
      check({tag, "_done_lo"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_wait_done"}, 32'(done), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      minuend = 8'd0;
      subtrahend = 8'd0;
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_borrow", 32'(borrow), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op("200m57", 8'd200, 8'd57, 8'd143, 1'b0);
      run_op("57m200", 8'd57, 8'd200, 8'd113, 1'b1);
      run_op("0m1", 8'd0, 8'd1, 8'd255, 1'b1);
      run_op("255m255", 8'd255, 8'd255, 8'd0, 1'b0);
      run_op("0m0", 8'd0, 8'd0, 8'd0, 1'b0);

      // start during RUN is ignored
      @(negedge clk);
      start = 1'b1;
      minuend = 8'd10;
      subtrahend = 8'd3;
      tick();
      start = 1'b0;
      repeat (3) tick();
      start = 1'b1;
      minuend = 8'd1;
      subtrahend = 8'd2;
      tick();
      start = 1'b0;
      check("ign_busy", 32'(busy), 32'd1);
      repeat (4) tick();
      check("ign_done", 32'(done), 32'd1);
      check("ign_result", 32'(result), 32'd7);
      check("ign_borrow", 32'(borrow), 32'd0);
      tick();
      check("ign_idle", 32'(done), 32'd0);

      // held start: DONE every 9 cycles, no idle gap
      @(negedge clk);
      start = 1'b1;
      minuend = 8'd100;
      subtrahend = 8'd1;
      tick();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 8; i++) begin
            check("held_busy", 32'(busy), 32'd1);
            check("held_nodone", 32'(done), 32'd0);
            tick();
         end
         check("held_done", 32'(done), 32'd1);
         check("held_busy_lo", 32'(busy), 32'd0);
         check("held_result", 32'(result), 32'd99);
         check("held_borrow", 32'(borrow), 32'd0);
         tick();
      end
      check("held_rerun", 32'(busy), 32'd1);
      start = 1'b0;
      wait_done("held_drain", 20);
      tick();
      check("held_idle", 32'(busy), 32'd0);

      // asynchronous reset mid-RUN
      @(negedge clk);
      start = 1'b1;
      minuend = 8'd200;
      subtrahend = 8'd57;
      tick();
      start = 1'b0;
      repeat (3) tick();
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_result", 32'(result), 32'd0);
      check("arst_borrow", 32'(borrow), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("arst_nodone", 32'(done), 32'd0);
         check("arst_noresult", 32'(result), 32'd0);
      end
      run_op("5m9", 8'd5, 8'd9, 8'd252, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
